// File: rtl/syscall_console_unit.sv
// syscall_console_unit
// Services syscalls accepted in the M stage: print_int (v0=1), print_string
// (v0=4), exit (v0=10) and print_char (v0=11). It emits ASCII bytes on a
// valid/ready stream. String bytes are read through the data memory print
// port. busy stalls fetch and decode until the service completes.
//
// Optional feature: define SYSCALL_CONSOLE_HEX_EN to add print_hex (v0=34).
// This prints "0x" followed by 8 lowercase hex digits. Without the macro,
// v0=34 is treated as an unsupported code.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   sig_syscall     one-cycle pulse, syscall present in M stage
//   v0, a0          service code and argument, sampled with sig_syscall
//   busy            stall request (combinational, covers the acceptance cycle)
//   sig_print_addr  byte address presented to the memory print port
//   print_word      word read combinationally at sig_print_addr
//   char_out        ASCII byte
//   char_valid      char_out is valid
//   char_ready      sink accepts the byte
//   sig_halted      exit has been serviced
//   sig_bad_syscall one-cycle pulse for an unsupported or rejected syscall
module syscall_console_unit #(
  parameter int MAX_STR_LEN = 256,
  parameter int INT_DIGITS  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sig_syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        busy,
  output logic [31:0] sig_print_addr,
  input  logic [31:0] print_word,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        sig_halted,
  output logic        sig_bad_syscall
);

  localparam int BCD_W = 4 * INT_DIGITS;
  localparam logic [16:0] STR_LIMIT = 17'(MAX_STR_LEN);

  typedef enum logic [2:0] {
    IDLE, FETCH, EMIT_STR, CONV, EMIT_INT, EMIT_CHAR, HALT
`ifdef SYSCALL_CONSOLE_HEX_EN
    , EMIT_HEX
`endif
  } state_t;

  state_t             state;
  logic [31:0]        ptr;
  logic [16:0]        cnt;
  logic [31:0]        bin;
  logic [BCD_W-1:0]   bcd;
  logic [5:0]         bit_cnt;
  logic               neg;
  logic               minus_pending;
  logic [3:0]         digit_idx;
`ifdef SYSCALL_CONSOLE_HEX_EN
  logic [31:0]        hex_val;
  logic [3:0]         hex_idx;
`endif

  logic [7:0]         fetch_byte;
  logic [16:0]        cnt_next;
  logic [BCD_W-1:0]   bcd_next;
  logic [3:0]         lead_next;
  logic [7:0]         first_digit;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next
  // magnitude bit.
  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b,
                                              input logic in_bit);
    logic [BCD_W-1:0] adj;
    adj = b;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], in_bit};
  endfunction

  // Index of the most significant nonzero digit. The result is 0 for a zero
  // value, so a single '0' is still printed.
  function automatic logic [3:0] lead_of(input logic [BCD_W-1:0] b);
    logic [3:0] lead;
    lead = 4'd0;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (b[4*i +: 4] != 4'd0) lead = 4'(i);
    end
    return lead;
  endfunction

  function automatic logic [7:0] digit_char(input logic [BCD_W-1:0] b,
                                            input logic [3:0] idx);
    return {4'h3, b[4*int'(idx) +: 4]};
  endfunction

`ifdef SYSCALL_CONSOLE_HEX_EN
  // Character idx of "0xNNNNNNNN". idx 2 is the most significant nibble.
  function automatic logic [7:0] hex_char(input logic [31:0] val,
                                          input logic [3:0] idx);
    logic [3:0] nib;
    nib = val[4*(9-int'(idx)) +: 4];
    if (idx == 4'd0) return 8'h30;
    if (idx == 4'd1) return 8'h78;
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction
`endif

  assign busy           = (state != IDLE) || sig_syscall;
  assign sig_print_addr = ptr;

  always_comb begin
    case (ptr[1:0])
      2'd0:    fetch_byte = print_word[7:0];
      2'd1:    fetch_byte = print_word[15:8];
      2'd2:    fetch_byte = print_word[23:16];
      default: fetch_byte = print_word[31:24];
    endcase
    cnt_next    = cnt + 17'd1;
    bcd_next    = dabble(bcd, bin[31]);
    lead_next   = lead_of(bcd_next);
    first_digit = digit_char(bcd_next, lead_next);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      ptr             <= '0;
      cnt             <= '0;
      bin             <= '0;
      bcd             <= '0;
      bit_cnt         <= '0;
      neg             <= 1'b0;
      minus_pending   <= 1'b0;
      digit_idx       <= '0;
      char_out        <= '0;
      char_valid      <= 1'b0;
      sig_halted      <= 1'b0;
      sig_bad_syscall <= 1'b0;
`ifdef SYSCALL_CONSOLE_HEX_EN
      hex_val         <= '0;
      hex_idx         <= '0;
`endif
    end else begin
      sig_bad_syscall <= 1'b0;
      case (state)
        IDLE: begin
          if (sig_syscall) begin
            case (v0)
              32'd1: begin
                neg     <= a0[31];
                bin     <= a0[31] ? -a0 : a0;
                bcd     <= '0;
                bit_cnt <= '0;
                state   <= CONV;
              end
              32'd4: begin
                ptr   <= a0;
                cnt   <= '0;
                state <= FETCH;
              end
              32'd10: begin
                sig_halted <= 1'b1;
                state      <= HALT;
              end
              32'd11: begin
                char_out   <= a0[7:0];
                char_valid <= 1'b1;
                state      <= EMIT_CHAR;
              end
`ifdef SYSCALL_CONSOLE_HEX_EN
              32'd34: begin
                hex_val    <= a0;
                hex_idx    <= 4'd0;
                char_out   <= 8'h30;
                char_valid <= 1'b1;
                state      <= EMIT_HEX;
              end
`endif
              default: sig_bad_syscall <= 1'b1;
            endcase
          end
        end
        FETCH: begin
          if (fetch_byte == 8'h00) begin
            state <= IDLE;
          end else begin
            char_out   <= fetch_byte;
            char_valid <= 1'b1;
            state      <= EMIT_STR;
          end
        end
        EMIT_STR: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            ptr        <= ptr + 32'd1;
            cnt        <= cnt_next;
            state      <= (cnt_next == STR_LIMIT) ? IDLE : FETCH;
          end
        end
        CONV: begin
          bcd     <= bcd_next;
          bin     <= bin << 1;
          bit_cnt <= bit_cnt + 6'd1;
          // The last step already knows the digits, so the first byte is
          // presented on the same edge that leaves CONV.
          if (bit_cnt == 6'd31) begin
            digit_idx     <= lead_next;
            minus_pending <= neg;
            char_out      <= neg ? 8'h2D : first_digit;
            char_valid    <= 1'b1;
            state         <= EMIT_INT;
          end
        end
        EMIT_INT: begin
          if (char_ready) begin
            if (minus_pending) begin
              minus_pending <= 1'b0;
              char_out      <= digit_char(bcd, digit_idx);
            end else if (digit_idx == 4'd0) begin
              char_valid <= 1'b0;
              state      <= IDLE;
            end else begin
              digit_idx <= digit_idx - 4'd1;
              char_out  <= digit_char(bcd, digit_idx - 4'd1);
            end
          end
        end
        EMIT_CHAR: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            state      <= IDLE;
          end
        end
`ifdef SYSCALL_CONSOLE_HEX_EN
        EMIT_HEX: begin
          if (char_ready) begin
            if (hex_idx == 4'd9) begin
              char_valid <= 1'b0;
              state      <= IDLE;
            end else begin
              hex_idx  <= hex_idx + 4'd1;
              char_out <= hex_char(hex_val, hex_idx + 4'd1);
            end
          end
        end
`endif
        HALT: ;
        default: state <= IDLE;
      endcase
      // A syscall that arrives while a service is running is rejected. HALT
      // swallows syscalls silently.
      if (sig_syscall && state != IDLE && state != HALT) sig_bad_syscall <= 1'b1;
    end
  end

endmodule

// File: tb/tb_syscall_console_unit.sv
// Directed testbench for syscall_console_unit with hand-computed expectations.
// Honours SYSCALL_CONSOLE_HEX_EN for the v0=34 case.
module tb_syscall_console_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sig_syscall = 1'b0;
  logic [31:0] v0 = '0;
  logic [31:0] a0 = '0;
  logic        busy;
  logic [31:0] sig_print_addr;
  logic [31:0] print_word;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready = 1'b1;
  logic        sig_halted;
  logic        sig_bad_syscall;

  int compareCount = 0;
  int mismatchCount = 0;
  int negCount = 0;
  int busyCount = 0;
  int badCount = 0;
  int accNeg = 0;
  int memMode = 0;
  logic [7:0] rxQ[$];
  int rxT[$];

  syscall_console_unit #(.MAX_STR_LEN(256), .INT_DIGITS(10)) dut (
    .clk(clk), .reset(reset), .sig_syscall(sig_syscall), .v0(v0), .a0(a0),
    .busy(busy), .sig_print_addr(sig_print_addr), .print_word(print_word),
    .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
    .sig_halted(sig_halted), .sig_bad_syscall(sig_bad_syscall)
  );

  always #5 clk = ~clk;

  // Mode 1: "abc\0" at 0x10010000. Mode 2: 300 letters A..Z repeating at
  // 0x20000000. Everything else reads as zero.
  function automatic logic [7:0] memByte(input int mode, input logic [31:0] addr);
    if (mode == 1 && addr >= 32'h10010000 && addr < 32'h10010003)
      return 8'h61 + 8'(addr - 32'h10010000);
    if (mode == 2 && addr >= 32'h20000000 && addr < 32'h2000012C)
      return 8'h41 + 8'((addr - 32'h20000000) % 26);
    return 8'h00;
  endfunction

  always_comb begin
    logic [31:0] w;
    w = {sig_print_addr[31:2], 2'b00};
    print_word = {memByte(memMode, w + 32'd3), memByte(memMode, w + 32'd2),
                  memByte(memMode, w + 32'd1), memByte(memMode, w)};
  end

  always @(negedge clk) begin
    negCount++;
    if (busy) busyCount++;
    if (sig_bad_syscall) badCount++;
    if (char_valid && char_ready) begin
      rxQ.push_back(char_out);
      rxT.push_back(negCount);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] code, input logic [31:0] arg);
    @(posedge clk); #2;
    sig_syscall = 1'b1; v0 = code; a0 = arg;
    @(negedge clk); #1;
    accNeg = negCount;
    @(posedge clk); #2;
    sig_syscall = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic clearRx();
    rxQ.delete();
    rxT.delete();
    busyCount = 0;
  endtask

  task automatic checkString(input string tag, input string exp);
    checkOutput({tag, "_len"}, rxQ.size(), exp.len());
    for (int i = 0; i < exp.len() && i < rxQ.size(); i++)
      checkOutput($sformatf("%s_b%0d", tag, i), 32'(rxQ[i]), 32'(exp[i]));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_valid"}, 32'(char_valid), 32'd0);
    checkOutput({tag, "_char"}, 32'(char_out), 32'd0);
    checkOutput({tag, "_halted"}, 32'(sig_halted), 32'd0);
    checkOutput({tag, "_bad"}, 32'(sig_bad_syscall), 32'd0);
    checkOutput({tag, "_addr"}, sig_print_addr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] intArgs[4] = '{32'd0, 32'd305, 32'hFFFFFFFF, 32'h80000000};
  string intExp[4] = '{"0", "305", "-1", "-2147483648"};

  initial begin
    int b0;
    int sizeAtStall;
    int n;

    #1;
    checkResetOutputs("rst");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // print_char
    clearRx();
    applyStimulus(32'd11, 32'h00000141);
    waitIdle(20, "char");
    checkString("char", "A");
    checkOutput("char_busy", busyCount, 2);

    // print_string terminated by NUL at offset 3
    memMode = 1;
    clearRx();
    applyStimulus(32'd4, 32'h10010000);
    waitIdle(50, "str");
    checkString("str", "abc");
    checkOutput("str_busy", busyCount, 8);
    if (rxT.size() > 0) checkOutput("str_lat", rxT[0] - accNeg, 2);

    // print_int, first byte 33 cycles after the acceptance cycle
    for (int k = 0; k < 4; k++) begin
      clearRx();
      applyStimulus(32'd1, intArgs[k]);
      waitIdle(100, $sformatf("int%0d", k));
      checkString($sformatf("int%0d", k), intExp[k]);
      if (rxT.size() > 0) checkOutput($sformatf("int%0d_lat", k), rxT[0] - accNeg, 33);
    end

    // syscall while converting: rejected, conversion unaffected
    clearRx();
    b0 = badCount;
    applyStimulus(32'd1, 32'd305);
    repeat (5) @(posedge clk);
    applyStimulus(32'd11, 32'h42);
    waitIdle(100, "busyint");
    checkString("busyint", "305");
    checkOutput("busyint_bad", badCount - b0, 1);

    // long string capped at 256 bytes, with a 3-cycle sink stall
    memMode = 2;
    clearRx();
    applyStimulus(32'd4, 32'h20000000);
    n = 0;
    while (rxQ.size() < 100 && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("long_progress", 32'(rxQ.size() >= 100), 32'd1);
    @(posedge clk); #2;
    char_ready = 1'b0;
    sizeAtStall = rxQ.size();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("stall_byte2", 32'(char_out), 32'(8'h41 + (sizeAtStall % 26)));
    @(negedge clk); #1;
    checkOutput("stall_valid", 32'(char_valid), 32'd1);
    checkOutput("stall_byte3", 32'(char_out), 32'(8'h41 + (sizeAtStall % 26)));
    checkOutput("stall_norx", rxQ.size(), sizeAtStall);
    @(posedge clk); #2;
    char_ready = 1'b1;
    waitIdle(2000, "long");
    checkOutput("long_len", rxQ.size(), 256);
    for (int i = 0; i < 256 && i < rxQ.size(); i++)
      checkOutput($sformatf("long_b%0d", i), 32'(rxQ[i]), 32'(8'h41 + (i % 26)));

    // optional hex print and unsupported code
    clearRx();
    b0 = badCount;
    applyStimulus(32'd34, 32'h00ABCDEF);
    waitIdle(50, "hex");
    repeat (2) @(negedge clk);
`ifdef SYSCALL_CONSOLE_HEX_EN
    checkString("hex", "0x00abcdef");
    checkOutput("hex_bad", badCount - b0, 0);
    if (rxT.size() > 0) checkOutput("hex_lat", rxT[0] - accNeg, 1);
`else
    checkOutput("hex_len", rxQ.size(), 0);
    checkOutput("hex_bad", badCount - b0, 1);
`endif
    clearRx();
    b0 = badCount;
    applyStimulus(32'd7, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("bad7_pulses", badCount - b0, 1);
    checkOutput("bad7_len", rxQ.size(), 0);
    checkOutput("bad7_busy", 32'(busy), 32'd0);

    // reset in the middle of a string abandons the rest
    clearRx();
    applyStimulus(32'd4, 32'h20000000);
    n = 0;
    while (rxQ.size() < 10 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #2;
    reset = 1'b1;
    sizeAtStall = rxQ.size();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checkOutput("rstmid_norx", rxQ.size(), sizeAtStall);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);

    // exit: halted persists and later syscalls are ignored silently
    clearRx();
    applyStimulus(32'd10, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("halt_flag", 32'(sig_halted), 32'd1);
    checkOutput("halt_busy", 32'(busy), 32'd1);
    b0 = badCount;
    applyStimulus(32'd11, 32'h5A);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("halt_norx", rxQ.size(), 0);
    checkOutput("halt_nobad", badCount - b0, 0);
    checkOutput("halt_flag2", 32'(sig_halted), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checkResetOutputs("halt_rst");
    @(negedge clk);
    reset = 1'b0;

    // unit serves again after reset
    clearRx();
    applyStimulus(32'd11, 32'h5A);
    waitIdle(20, "after");
    checkString("after", "Z");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
